phy_tx: RTL and testbench



---
 rtl/phy_tx_if.sv | 26 ++
 rtl/phy_tx.sv | 109 ++++++++++
 tb/tb_phy_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/phy_tx_if.sv
// Byte-side and serial-side signals of the two-lane transmitter.
// The count_x outputs exist only when PHY_TX_BYTE_COUNT_EN is defined.
interface phy_tx_if;
    logic       enable;
    logic [7:0] data_in_0;
    logic [7:0] data_in_1;
    logic       valid_in_0;
    logic       valid_in_1;
    logic       ready_out;
    logic       out_0;
    logic       out_1;
`ifdef PHY_TX_BYTE_COUNT_EN
    logic [15:0] count_0;
    logic [15:0] count_1;

    modport master (output enable, data_in_0, data_in_1, valid_in_0, valid_in_1,
                    input ready_out, out_0, out_1, count_0, count_1);
    modport slave  (input enable, data_in_0, data_in_1, valid_in_0, valid_in_1,
                    output ready_out, out_0, out_1, count_0, count_1);
`else
    modport master (output enable, data_in_0, data_in_1, valid_in_0, valid_in_1,
                    input ready_out, out_0, out_1);
    modport slave  (input enable, data_in_0, data_in_1, valid_in_0, valid_in_1,
                    output ready_out, out_0, out_1);
`endif
endinterface

// File: rtl/phy_tx.sv
// Two-lane MSB-first serializer with comma preamble and comma idle fill.
// Define PHY_TX_BYTE_COUNT_EN to add per-lane accepted-byte counters.
//
// state  | meaning
// SYNC   | sending preamble commas (or 00 while disabled), no data accepted
// ACTIVE | accepting one byte per lane at each boundary, comma when not valid
module phy_tx #(
    parameter int         MIN_COMMAS = 4,
    parameter logic [7:0] COMMA      = 8'hBC
) (
    input  logic    clk_8f,
    input  logic    reset,
    phy_tx_if.slave tx
);
    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt;
    logic [3:0] comma_cnt, comma_nxt;
    logic [7:0] shift_0, shift_1;
    logic [7:0] byte_0, byte_1;
    logic       out_0_q, out_1_q;
    logic       load, ready;

    assign load = (bit_cnt == 3'd7);

    always_comb begin
        state_nxt = state;
        comma_nxt = comma_cnt;
        byte_0    = 8'h00;
        byte_1    = 8'h00;
        ready     = 1'b0;
        case (state)
            SYNC: begin
                if (load && tx.enable) begin
                    byte_0 = COMMA;
                    byte_1 = COMMA;
                    if (comma_cnt == 4'(MIN_COMMAS - 1)) begin
                        state_nxt = ACTIVE;
                        comma_nxt = 4'd0;
                    end else begin
                        comma_nxt = comma_cnt + 4'd1;
                    end
                end else if (load) begin
                    comma_nxt = 4'd0;
                end
            end
            ACTIVE: begin
                ready = load && tx.enable;
                if (load && tx.enable) begin
                    byte_0 = tx.valid_in_0 ? tx.data_in_0 : COMMA;
                    byte_1 = tx.valid_in_1 ? tx.data_in_1 : COMMA;
                end else if (load) begin
                    state_nxt = SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= SYNC;
            bit_cnt   <= 3'd7;
            comma_cnt <= 4'd0;
            shift_0   <= 8'h00;
            shift_1   <= 8'h00;
            out_0_q   <= 1'b0;
            out_1_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt + 3'd1;
            comma_cnt <= comma_nxt;
            if (load) begin
                out_0_q <= byte_0[7];
                out_1_q <= byte_1[7];
                shift_0 <= {byte_0[6:0], 1'b0};
                shift_1 <= {byte_1[6:0], 1'b0};
            end else begin
                out_0_q <= shift_0[7];
                out_1_q <= shift_1[7];
                shift_0 <= {shift_0[6:0], 1'b0};
                shift_1 <= {shift_1[6:0], 1'b0};
            end
        end
    end

    assign tx.ready_out = ready;
    assign tx.out_0     = out_0_q;
    assign tx.out_1     = out_1_q;

`ifdef PHY_TX_BYTE_COUNT_EN
    logic [15:0] count_0_q, count_1_q;

    // A lane byte is counted only when it is actually taken on a ready cycle.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            count_0_q <= 16'd0;
            count_1_q <= 16'd0;
        end else begin
            if (ready && tx.valid_in_0) count_0_q <= count_0_q + 16'd1;
            if (ready && tx.valid_in_1) count_1_q <= count_1_q + 16'd1;
        end
    end

    assign tx.count_0 = count_0_q;
    assign tx.count_1 = count_1_q;
`endif
endmodule

// File: tb/tb_phy_tx.sv
// Randomized and directed stimulus for phy_tx against a bit-queue reference model.
module tb_phy_tx;
    localparam int         MIN   = 4;
    localparam logic [7:0] COMMA = 8'hBC;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    phy_tx_if ifc ();

    phy_tx #(.MIN_COMMAS(MIN), .COMMA(COMMA)) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .tx     (ifc.slave)
    );

    always #5 clk_8f = ~clk_8f;

    // Reference model: expected serial bits per lane held as queues.
    bit          q0[$], q1[$];
    int          slot;          // position within the current byte, 7 = boundary next
    int          commas;        // consecutive preamble commas sent so far
    bit          active;
    logic [15:0] cnt0, cnt1;
    logic        last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 7; i >= 0; i--) begin
            q0.push_back(b0[i]);
            q1.push_back(b1[i]);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v0, input logic v1,
                        input logic [7:0] d0, input logic [7:0] d1);
        logic exp0, exp1, exp_ready;
        reset = r; ifc.enable = e;
        ifc.valid_in_0 = v0; ifc.valid_in_1 = v1;
        ifc.data_in_0 = d0;  ifc.data_in_1 = d1;
        #1;
        exp_ready  = active && (slot == 7) && e;
        last_ready = ifc.ready_out;
        if (!r) check("ready_out", ifc.ready_out, exp_ready);
        if (r) begin
            q0.delete(); q1.delete();
            slot = 7; commas = 0; active = 0; cnt0 = 0; cnt1 = 0;
            exp0 = 0; exp1 = 0;
        end else begin
            if (slot == 7) begin
                if (!e) begin
                    push_byte(8'h00, 8'h00);
                    commas = 0; active = 0;
                end else if (!active) begin
                    push_byte(COMMA, COMMA);
                    commas++;
                    if (commas == MIN) begin active = 1; commas = 0; end
                end else begin
                    push_byte(v0 ? d0 : COMMA, v1 ? d1 : COMMA);
                    if (v0) cnt0 = cnt0 + 16'd1;
                    if (v1) cnt1 = cnt1 + 16'd1;
                end
            end
            slot = (slot + 1) % 8;
            exp0 = q0.pop_front();
            exp1 = q1.pop_front();
        end
        @(posedge clk_8f); #1;
        check("out_0", ifc.out_0, exp0);
        check("out_1", ifc.out_1, exp1);
`ifdef PHY_TX_BYTE_COUNT_EN
        check("count_0", ifc.count_0, cnt0);
        check("count_1", ifc.count_1, cnt1);
`endif
    endtask

    // Hold valid bytes until the model predicts a ready cycle, then present them once.
    task automatic send(input logic [7:0] d0, input logic v0, input logic [7:0] d1, input logic v1);
        bit done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (active && slot == 7) begin
                step(0, 1, v0, v1, d0, d1);
                done = 1;
            end else begin
                step(0, 1, 0, 0, 8'h00, 8'h00);
            end
        end
        check("send_timeout", done, 1);
    endtask

    initial begin
        int low_cnt;
        bit seen;
        slot = 7; commas = 0; active = 0; cnt0 = 0; cnt1 = 0;

        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(1, 1, 0, 0, 8'h00, 8'h00);

        // Preamble: count cycles before the first ready pulse.
        low_cnt = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(0, 1, 0, 0, 8'h00, 8'h00);
            if (last_ready === 1'b1) seen = 1; else low_cnt++;
        end
        check("first_ready", low_cnt, 8 * MIN);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 8'h00, 8'h00);

        send(8'hFF, 1, 8'h11, 0);
        send(8'hEE, 1, 8'hEE, 1);
        send(8'hDD, 1, 8'hDD, 1);
        send(8'h99, 1, 8'h11, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00, 8'h00);

        // Enable dropped mid-byte across one boundary, valid held through the resync window.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 8'h5A, 8'hA5);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 1, 8'h5A, 8'hA5);

        // Reset in the middle of a data byte.
        send(8'h88, 1, 8'h22, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00, 8'h00);
        step(1, 1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 8'h00, 8'h00);

        // Counter scenario: three lane-0 bytes, one lane-1 byte, then reset.
        send(8'h01, 1, 8'h00, 0);
        send(8'h02, 1, 8'h77, 1);
        send(8'h03, 1, 8'h00, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00, 8'h00);
`ifdef PHY_TX_BYTE_COUNT_EN
        check("count_0_sum", ifc.count_0, 16'd3);
        check("count_1_sum", ifc.count_1, 16'd1);
`endif
        step(1, 1, 0, 0, 8'h00, 8'h00);
`ifdef PHY_TX_BYTE_COUNT_EN
        check("count_0_rst", ifc.count_0, 16'd0);
        check("count_1_rst", ifc.count_1, 16'd0);
`endif

        // Random traffic with occasional enable toggles and resets.
        begin
            logic en = 1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 149) == 0) en = ~en;
                step($urandom_range(0, 599) == 0, en,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
